// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, window debounce FSM and
// single-cycle press / release / long-press event pulses.
module button_conditioner #(
    parameter int CLK_IN       = 50_000_000,
    parameter int DB_FREQ      = 100,
    parameter int HOLD_WINDOWS = 200
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int N    = CLK_IN / DB_FREQ;
    localparam int HOLD = N * HOLD_WINDOWS;
    localparam int CW   = $clog2(N);
    localparam int HW   = $clog2(HOLD + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(N - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] db_cnt, db_cnt_next;
    logic [HW-1:0] hold_cnt, hold_cnt_next;
    logic          s1, s2;
    logic          press_next, release_next, long_next;

    // The synchronizer keeps running while disabled so a held button is
    // already visible on s2 when enable returns.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_button;
            s2 <= s1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            state     <= state_next;
            db_cnt    <= db_cnt_next;
            hold_cnt  <= hold_cnt_next;
            o_press   <= press_next;
            o_release <= release_next;
            o_long    <= long_next;
        end
    end

    always_comb begin
        state_next    = state;
        db_cnt_next   = db_cnt;
        hold_cnt_next = '0;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;

        case (state)
            IDLE: begin
                db_cnt_next = '0;
                if (s2) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = CW'(1);
                end
            end
            DB_PRESS: begin
                if (!s2) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                    press_next  = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + CW'(1);
                end
            end
            HELD: begin
                db_cnt_next = '0;
                if (!s2) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = CW'(1);
                end
            end
            DB_RELEASE: begin
                if (s2) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next   = IDLE;
                    db_cnt_next  = '0;
                    release_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + CW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase

        // Hold timer runs only while the debounced level is high and
        // saturates so the long pulse fires once per press.
        if ((state == HELD || state == DB_RELEASE) && state_next != IDLE) begin
            hold_cnt_next = hold_cnt;
            if (hold_cnt < HOLD_MAX) begin
                hold_cnt_next = hold_cnt + HW'(1);
            end
            long_next = (hold_cnt == HOLD_LAST) && !release_next;
        end

        if (!i_en) begin
            state_next    = IDLE;
            db_cnt_next   = '0;
            hold_cnt_next = '0;
            press_next    = 1'b0;
            release_next  = 1'b0;
            long_next     = 1'b0;
        end
    end

    always_comb begin
        o_level = (state == HELD) || (state == DB_RELEASE);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with N=5 and a 20-cycle hold time;
// pulse positions are logged per segment and compared to hand-derived cycles.
module tb_button_conditioner;

    logic i_clk = 1'b0;
    logic i_reset, i_en, i_button;
    logic o_level, o_press, o_release, o_long;

    int total = 0;
    int bad   = 0;

    int cyc, pressCnt, releaseCnt, longCnt, levelHighCnt, multiHot;
    int pressAt, releaseAt, longAt, levelAtPress;

    button_conditioner #(
        .CLK_IN      (500),
        .DB_FREQ     (100),
        .HOLD_WINDOWS(4)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_en     (i_en),
        .i_button (i_button),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long)
    );

    always #1 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        cyc          = 0;
        pressCnt     = 0;
        releaseCnt   = 0;
        longCnt      = 0;
        levelHighCnt = 0;
        pressAt      = -1;
        releaseAt    = -1;
        longAt       = -1;
        levelAtPress = -1;
    endtask

    // Drive inputs for n cycles; cycle k of a segment is its k-th rising edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic btn, input int n);
        for (int i = 0; i < n; i++) begin
            i_reset  = rst;
            i_en     = en;
            i_button = btn;
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            if (o_press) begin
                pressCnt++;
                pressAt      = cyc;
                levelAtPress = int'(o_level);
            end
            if (o_release) begin
                releaseCnt++;
                releaseAt = cyc;
            end
            if (o_long) begin
                longCnt++;
                longAt = cyc;
            end
            if (o_level) levelHighCnt++;
            if (int'(o_press) + int'(o_release) + int'(o_long) > 1) multiHot++;
        end
    endtask

    initial begin
        multiHot = 0;
        clearLog();

        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        checkOutput("reset_outputs", int'({o_level, o_press, o_release, o_long}), 0);
        checkOutput("reset_pulses", pressCnt + releaseCnt + longCnt, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        checkOutput("clean_press_at", pressAt, 7);
        checkOutput("clean_press_count", pressCnt, 1);
        checkOutput("clean_level_at_press", levelAtPress, 1);
        checkOutput("clean_no_early_long", longCnt, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        checkOutput("long_at", longAt, 27);
        checkOutput("long_count", longCnt, 1);
        checkOutput("long_level_held", int'(o_level), 1);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("long_release_at", releaseAt, 7);
        checkOutput("long_release_count", releaseCnt, 1);
        checkOutput("long_level_after_release", int'(o_level), 0);
        checkOutput("long_no_repeat", longCnt, 0);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("glitch_pulses", pressCnt + releaseCnt + longCnt, 0);
        checkOutput("glitch_level", levelHighCnt, 0);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 12);
        checkOutput("bounce_press_at", pressAt, 12);
        checkOutput("bounce_press_count", pressCnt, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("bounce_release_at", releaseAt, 24);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 12);
        applyStimulus(1'b0, 1'b1, 1'b0, 20);
        checkOutput("short_press_at", pressAt, 7);
        checkOutput("short_release_at", releaseAt, 19);
        checkOutput("short_no_long", longCnt, 0);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("coincide_release_at", releaseAt, 27);
        checkOutput("coincide_long_suppressed", longCnt, 0);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 21);
        applyStimulus(1'b0, 1'b1, 1'b0, 15);
        checkOutput("edge_long_at", longAt, 27);
        checkOutput("edge_release_at", releaseAt, 28);

        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("pre_reset_level", int'(o_level), 1);
        clearLog();
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("midreset_level", int'(o_level), 0);
        checkOutput("midreset_pulses", pressCnt + releaseCnt + longCnt, 0);
        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("midreset_repress_at", pressAt, 7);
        checkOutput("midreset_no_release", releaseCnt, 0);

        clearLog();
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        checkOutput("disable_level", levelHighCnt, 0);
        checkOutput("disable_pulses", pressCnt + releaseCnt + longCnt, 0);
        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("enable_press_at", pressAt, 5);

        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("pulse_exclusive", multiHot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
